// File: rtl/inst_encoder.sv
// Packs field-level RV32I instruction descriptors into machine words and streams
// them to consecutive IMEM byte addresses; unencodable descriptors become a NOP and set err.
module inst_encoder #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_alt,
    input  logic [31:0]       in_imm,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  count
);

    typedef enum logic {IDLE, LOAD} state_t;

    localparam logic [3:0] OP_LUI    = 4'd0;
    localparam logic [3:0] OP_AUIPC  = 4'd1;
    localparam logic [3:0] OP_JAL    = 4'd2;
    localparam logic [3:0] OP_JALR   = 4'd3;
    localparam logic [3:0] OP_BRANCH = 4'd4;
    localparam logic [3:0] OP_LOAD   = 4'd5;
    localparam logic [3:0] OP_STORE  = 4'd6;
    localparam logic [3:0] OP_ALI    = 4'd7;
    localparam logic [3:0] OP_ALR    = 4'd8;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [LEN_W-1:0]    count_q, count_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [31:0]         wdata_q, wdata_d;

    // Immediate range checks: sign-extension bits must all agree.
    logic imm_i12, imm_b13, imm_j21, shamt_ok;
    assign imm_i12  = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign imm_b13  = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) && !in_imm[0];
    assign imm_j21  = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) && !in_imm[0];
    assign shamt_ok = (in_imm[31:5] == '0);

    logic [6:0]  funct7;
    logic [31:0] enc_raw, enc_word;
    logic        enc_bad;
    assign funct7 = {1'b0, in_alt, 5'b0_0000};

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        enc_raw = NOP;
        enc_bad = 1'b0;
        case (in_op)
            OP_LUI: begin
                enc_bad = (in_imm[11:0] != '0);
                enc_raw = {in_imm[31:12], in_rd, 7'h37};
            end
            OP_AUIPC: begin
                enc_bad = (in_imm[11:0] != '0);
                enc_raw = {in_imm[31:12], in_rd, 7'h17};
            end
            OP_JAL: begin
                enc_bad = !imm_j21;
                enc_raw = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'h6F};
            end
            OP_JALR: begin
                enc_bad = !imm_i12;
                enc_raw = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'h67};
            end
            OP_BRANCH: begin
                enc_bad = !imm_b13 || (in_funct3 == 3'd2) || (in_funct3 == 3'd3);
                enc_raw = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], 7'h63};
            end
            OP_LOAD: begin
                enc_bad = !imm_i12 || (in_funct3 == 3'd3) || (in_funct3 >= 3'd6);
                enc_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'h03};
            end
            OP_STORE: begin
                enc_bad = !imm_i12 || (in_funct3 >= 3'd3);
                enc_raw = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'h23};
            end
            OP_ALI: begin
                if (in_funct3 == 3'd1) begin
                    enc_bad = !shamt_ok;
                    enc_raw = {7'h00, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'h13};
                end else if (in_funct3 == 3'd5) begin
                    enc_bad = !shamt_ok;
                    enc_raw = {funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'h13};
                end else begin
                    enc_bad = !imm_i12;
                    enc_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'h13};
                end
            end
            OP_ALR: begin
                enc_raw = {funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'h33};
            end
            default: enc_bad = 1'b1;
        endcase
        enc_word = enc_bad ? NOP : enc_raw;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        count_d   = count_q;
        err_d     = err_q;
        done_d    = 1'b0;
        we_d      = 1'b0;
        im_addr_d = im_addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = {base[ADDR_W-1:2], 2'b00};
                    rem_d   = len;
                    count_d = '0;
                    err_d   = 1'b0;
                    if (len == '0) done_d = 1'b1;
                    else           state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    we_d      = 1'b1;
                    im_addr_d = addr_q;
                    wdata_d   = enc_word;
                    addr_d    = addr_q + ADDR_W'(4);
                    count_d   = count_q + LEN_W'(1);
                    rem_d     = rem_q - LEN_W'(1);
                    if (enc_bad) err_d = 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
            im_addr_q <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            count_q   <= count_d;
            err_q     <= err_d;
            done_q    <= done_d;
            we_q      <= we_d;
            im_addr_q <= im_addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign in_ready = (state_q == LOAD);
    assign busy     = (state_q == LOAD);
    assign im_we    = we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = wdata_q;
    assign done     = done_q;
    assign err      = err_q;
    assign count    = count_q;

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the core's instruction decode path: accepts a stream of field-level instruction descriptors and packs each into a legal RV32I machine word.
- Writes the packed words to consecutive instruction-memory locations through a single write port.
- Used by the debug/boot path to load programs into IMEM without a host assembler.
- Range-checks every descriptor; an unencodable descriptor is replaced by a NOP and flagged.

Parameters:
ADDR_W, 12, IMEM byte-address width; write address wraps modulo 2^ADDR_W
LEN_W, 10, width of the program-length input

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse; begins a load session (honoured only in IDLE)
base  input  ADDR_W  first write byte address; bits [1:0] treated as 0
len  input  LEN_W  number of instructions to encode this session
in_valid  input  1  descriptor valid
in_ready  output  1  descriptor accepted when in_valid & in_ready
in_op  input  4  class: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 ALI, 8 ALR, others illegal
in_rd / in_rs1 / in_rs2  input  5 each  register fields
in_funct3  input  3  funct3 / branch-load-store type
in_alt  input  1  funct7[5] (SUB/SRA/SRAI)
in_imm  input  32  signed byte offset or immediate value; for LUI/AUIPC, the full 32-bit value
im_we  output  1  IMEM write strobe
im_addr  output  ADDR_W  IMEM write byte address
im_wdata  output  32  encoded instruction
busy  output  1  state == LOAD
done  output  1  one-cycle pulse at session end
err  output  1  sticky illegal/out-of-range flag; cleared by start
count  output  LEN_W  words written this session

Behaviour:
- Reset: state IDLE. All outputs 0: in_ready, im_we, im_addr, im_wdata, busy, done, err, count. Internal address and remaining-count registers cleared.
- FSM, two states:
  - IDLE: start at cycle t → LOAD at t+1; addr = {base[ADDR_W-1:2],2'b00}; remaining = len; count = 0; err = 0.
  - If len == 0: stay IDLE instead; done = 1 at t+1; no writes.
  - start while in LOAD is ignored.
- in_ready = (state == LOAD), combinational from state only.
- Accept at cycle t → registered write at t+1:
  - im_we = 1, im_addr = addr, im_wdata = encoded word.
  - addr += 4 (wraps modulo 2^ADDR_W); count += 1; remaining -= 1.
- When remaining reaches 0 on an accept at t: state = IDLE at t+1; done = 1 at t+1, the same cycle as the last write.
- im_we is 0 in every cycle that does not follow an accept; im_wdata holds its last value.
- Encoding, with op the standard 7-bit opcode for the class:
  - ALR: {in_alt?7'h20:7'h00, rs2, rs1, f3, rd, op}.
  - ALI, f3=001: {7'h00, imm[4:0], rs1, f3, rd, op}.
  - ALI, f3=101: {in_alt?7'h20:7'h00, imm[4:0], rs1, f3, rd, op}.
  - ALI, other f3: {imm[11:0], rs1, f3, rd, op}.
  - LOAD: {imm[11:0], rs1, f3, rd, op}.
  - JALR: {imm[11:0], rs1, 3'b000, rd, op}.
  - STORE: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - LUI/AUIPC: {imm[31:12], rd, op}.
- Illegal conditions; each writes 32'h00000013 (NOP) and sets err:
  - Illegal in_op.
  - I/S imm not 12-bit signed.
  - Shift imm outside 0..31.
  - B imm not 13-bit signed, or odd.
  - J imm not 21-bit signed, or odd.
  - LUI/AUIPC imm[11:0] ≠ 0.
  - LOAD f3 ∈ {3,6,7}; STORE f3 ≥ 3; BRANCH f3 ∈ {2,3}.
- err timing: asserts in the cycle of the offending write and stays set until the next accepted start.
- rst mid-session: session aborted, returns to reset state; no done pulse.

Test Plan:
1. start, base=0x100, len=3; descriptors addi x1,x0,5 / add x3,x1,x2 / sub x3,x1,x2 → writes 0x00500093@0x100, 0x002081B3@0x104, 0x402081B3@0x108; done coincides with the third write; count=3; err=0.
2. lui x5,0x12345000; jal x1,+8; beq x1,x2,-4; sw x2,8(x1); srai x4,x1,3 → 0x123452B7, 0x008000EF, 0xFE208EE3, 0x0020A423, 0x4030D213.
3. Illegal descriptors: addi imm=2048; beq imm=3; in_op=12 → each writes 0x00000013 and err=1. A following start clears err; next legal write leaves err=0.
4. base=0xFFC (ADDR_W=12), len=2 → writes at 0xFFC then 0x000. Also: len=0 → done one cycle after start, im_we never asserted.
5. in_valid toggled 1,0,0,1; start pulsed mid-session → writes only follow accepts; mid-session start ignored; rst asserted after the first write → all outputs 0 next cycle, no done.
